rf_wr_arbiter: RTL and testbench
================================

// Module: rf_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single register-file write port (DW-wide bank of d_ff bits) among N requesters (ALU, load unit, ...).
//  Accepts one write per cycle into a one-entry output stage, holds it until the register file signals ready, and acknowledges the winning requester.
//  Sits between the execute/writeback sources and the register-file write port.
// PARAMETERS
//  N   4   number of requesters (2..8)
//  DW  8   write data width
//  AW  3   register address width
//  IW  2   grant-id width, >= clog2(N)
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     asynchronous, active-high reset
//  req        in   N     request per requester; held with addr/data until its ack
//  req_addr   in   N*AW  packed addresses, requester i at [i*AW +: AW]
//  req_data   in   N*DW  packed data, requester i at [i*DW +: DW]
//  rf_ready   in   1     register file accepts rf_we on this edge
//  ack        out  N     one-cycle, one-hot pulse: request i captured
//  rf_we      out  1     output stage holds a valid write
//  rf_waddr   out  AW    write address
//  rf_wdata   out  DW    write data
//  grant_id   out  IW    index of requester owning the output stage
//  busy       out  1     rf_we & ~rf_ready (stage stalled)
// BEHAVIOUR
//  Reset (async, immediate): rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, ack=0, busy=0, state=EMPTY, priority ptr=0 (req 0 highest).
//  Any write pending at reset is discarded; rf_we drops during reset, not at the next edge.
//  FSM on the output stage, 2 states:
//   EMPTY: rf_we=0. If any eligible req -> load winner, go FULL.
//   FULL:  rf_we=1. If rf_ready: load a new winner (stay FULL) or, with none, go EMPTY.
//          If ~rf_ready: hold addr/data/grant_id stable, grant nothing.
//  Capture allowed when state==EMPTY or (FULL & rf_ready). Back-to-back writes at 1 per cycle with rf_ready tied high.
//  Eligible = req & ~ack: a requester acked this cycle is masked, so it can still hold req during its ack cycle without a double grant.
//  Winner: first eligible index at or after ptr, searching ptr, ptr+1, ... mod N.
//  On capture of winner w: ptr <= (w+1) mod N. ptr is unchanged when nothing is captured.
//  Latency: req sampled at edge E -> rf_we/addr/data/grant_id valid and ack[w]=1 after E.
//   ack is registered, high exactly one cycle.
//  Simultaneous requests: served strictly in round-robin order; none is starved (max wait N-1 grants).
//  No address merging or forwarding: two writes to the same address retire in grant order.
//  Requester releasing req before ack: that request is withdrawn, nothing is written.
//  ptr wraps from N-1 to 0. Unused grant_id codes are never produced.
// STRUCTURE
//  Shared header cpu_defs.vh holds:
//   - FSM state encodings (ST_EMPTY=1'b0, ST_FULL=1'b1)
//   - defaults for DW/AW so the register file and the arbiter agree
//  Sub-module rr_pick (combinational): inputs eligible[N] and ptr[IW]; outputs found and win[IW].
//   Implemented as a double-width rotate plus a priority encoder.
//  The top level holds the FSM, the output-stage registers, ack and ptr.
// TESTING
//  1. Reset mid-FULL, rf_ready=0, stage holding addr 5/data 8'hA5 -> rf_we=0 immediately, all outputs 0, ptr=0.
//  2. req=4'b0100 alone, addr 3, data 8'h3C, rf_ready=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=8'h3C,
//     grant_id=2, ack=4'b0100 for 1 cycle.
//  3. req=4'b1111 held, rf_ready=1 -> grant_id 0,1,2,3,0 on consecutive cycles; each ack one-hot, one cycle.
//  4. rf_ready=0 for 3 cycles while FULL with req=4'b0011 pending -> outputs stable, busy=1, ack=0.
//     rf_ready=1 -> next requester captured and acked.
//  5. Requester 1 keeps req high through its ack cycle -> no second grant to 1 in that cycle; winner is the next eligible.
//  6. ptr=3, req=4'b1001 -> grant 3 then 0 (wrap); req dropped before ack -> no rf_we for that request.

Source files
------------

// File: rtl/rf_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: output-stage FSM
// encoding and default data/address widths that the register file also uses.
package rf_wr_arbiter_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int RF_DW = 8;
    localparam int RF_AW = 3;

endpackage

// File: rtl/rf_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotates the eligible vector so that the
// pointer position lands at bit 0, then priority-encodes the lowest set bit.
module rf_wr_arbiter_rr_pick
    import rf_wr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] win
);

    logic [N-1:0] rot;
    int           sum;

    always_comb begin
        rot   = N'({eligible, eligible} >> ptr);
        found = 1'b0;
        win   = '0;
        sum   = 0;
        // Scan downwards so the lowest rotated index (closest to ptr) wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                sum   = int'(ptr) + k;
                if (sum >= N) begin
                    sum = sum - N;
                end
                win = IW'(sum);
            end
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter feeding the single register-file write port through a
// one-entry output stage; acks the captured requester with a one-cycle pulse.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = RF_DW,
    parameter int AW = RF_AW,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_data,
    input  logic          rf_ready,
    output logic [N-1:0]  ack,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [IW-1:0] grant_id,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [IW-1:0] gid_q, gid_d;

    logic [N-1:0]  eligible;
    logic          found;
    logic [IW-1:0] win;
    logic          capture;

    // A requester still holding req during its ack cycle must not win again.
    assign eligible = req & ~ack_q;

    rf_wr_arbiter_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .found    (found),
        .win      (win)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        gid_d   = gid_q;
        capture = found && ((state_q == ST_EMPTY) || rf_ready);

        case (state_q)
            ST_EMPTY: if (found) state_d = ST_FULL;
            ST_FULL:  if (rf_ready && !found) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (capture) begin
            waddr_d = req_addr[int'(win) * AW +: AW];
            wdata_d = req_data[int'(win) * DW +: DW];
            gid_d   = win;
            ack_d   = N'(1) << win;
            ptr_d   = (win == IW'(N - 1)) ? '0 : win + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            ack_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
        end
    end

    assign ack      = ack_q;
    assign rf_we    = (state_q == ST_FULL);
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign grant_id = gid_q;
    assign busy     = rf_we & ~rf_ready;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter (N=4, DW=8, AW=3, IW=2).
module tb_rf_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic        rf_ready;
    logic [3:0]  ack;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic [1:0]  grant_id;
    logic        busy;

    int tests = 0;
    int fails = 0;

    rf_wr_arbiter #(.N(4), .DW(8), .AW(3), .IW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .rf_ready (rf_ready),
        .ack      (ack),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_full(input string tag, input logic [2:0] a, input logic [7:0] d,
                               input logic [1:0] g, input logic [3:0] k, input logic b);
        chk({tag, ".we"},   32'(rf_we),    32'd1);
        chk({tag, ".addr"}, 32'(rf_waddr), 32'(a));
        chk({tag, ".data"}, 32'(rf_wdata), 32'(d));
        chk({tag, ".gid"},  32'(grant_id), 32'(g));
        chk({tag, ".ack"},  32'(ack),      32'(k));
        chk({tag, ".busy"}, 32'(busy),     32'(b));
    endtask

    task automatic expect_empty(input string tag);
        chk({tag, ".we"},   32'(rf_we), 32'd0);
        chk({tag, ".ack"},  32'(ack),   32'd0);
        chk({tag, ".busy"}, 32'(busy),  32'd0);
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, ".we"},   32'(rf_we),    32'd0);
        chk({tag, ".addr"}, 32'(rf_waddr), 32'd0);
        chk({tag, ".data"}, 32'(rf_wdata), 32'd0);
        chk({tag, ".gid"},  32'(grant_id), 32'd0);
        chk({tag, ".ack"},  32'(ack),      32'd0);
        chk({tag, ".busy"}, 32'(busy),     32'd0);
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
        req[i]              = 1'b1;
        req_addr[i*3 +: 3]  = a;
        req_data[i*8 +: 8]  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        rf_ready = 1'b0;

        // Reset state, then fill the stage with a stalled write and reset mid-FULL.
        #12;
        expect_reset("rst_init");
        reset = 1'b0;
        set_req(1, 3'd5, 8'hA5);
        tick();
        expect_full("fill", 3'd5, 8'hA5, 2'd1, 4'b0010, 1'b1);
        req = '0;
        tick();
        expect_full("stall_pre_rst", 3'd5, 8'hA5, 2'd1, 4'b0000, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        expect_reset("rst_mid_full");
        reset = 1'b0;

        // All four requesting: strict round robin from ptr 0 (proves ptr reset).
        rf_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 3'(i + 4), 8'(8'h10 + i));
        tick(); expect_full("rr0", 3'd4, 8'h10, 2'd0, 4'b0001, 1'b0);
        tick(); expect_full("rr1", 3'd5, 8'h11, 2'd1, 4'b0010, 1'b0);
        tick(); expect_full("rr2", 3'd6, 8'h12, 2'd2, 4'b0100, 1'b0);
        tick(); expect_full("rr3", 3'd7, 8'h13, 2'd3, 4'b1000, 1'b0);
        tick(); expect_full("rr4", 3'd4, 8'h10, 2'd0, 4'b0001, 1'b0);
        req = '0;
        tick(); expect_empty("rr_drain");

        // Single requester 2 (ptr now 1).
        set_req(2, 3'd3, 8'h3C);
        tick(); expect_full("single2", 3'd3, 8'h3C, 2'd2, 4'b0100, 1'b0);
        req = '0;
        tick(); expect_empty("single2_ack1cyc");

        // ptr 3 with req 1001: grant 3 then wrap to 0.
        set_req(3, 3'd6, 8'h66);
        set_req(0, 3'd1, 8'h11);
        tick(); expect_full("wrap3", 3'd6, 8'h66, 2'd3, 4'b1000, 1'b0);
        req[3] = 1'b0;
        tick(); expect_full("wrap0", 3'd1, 8'h11, 2'd0, 4'b0001, 1'b0);
        req = '0;
        tick(); expect_empty("wrap_drain");

        // Stall with req 0011 (ptr 1), plus requester 2 withdrawing mid-stall.
        set_req(0, 3'd2, 8'h22);
        set_req(1, 3'd7, 8'h77);
        tick(); expect_full("st_cap", 3'd7, 8'h77, 2'd1, 4'b0010, 1'b0);
        req[1]   = 1'b0;
        rf_ready = 1'b0;
        tick(); expect_full("st_hold1", 3'd7, 8'h77, 2'd1, 4'b0000, 1'b1);
        set_req(2, 3'd4, 8'h44);
        tick(); expect_full("st_hold2", 3'd7, 8'h77, 2'd1, 4'b0000, 1'b1);
        req[2] = 1'b0;
        tick(); expect_full("st_hold3", 3'd7, 8'h77, 2'd1, 4'b0000, 1'b1);
        rf_ready = 1'b1;
        tick(); expect_full("st_release", 3'd2, 8'h22, 2'd0, 4'b0001, 1'b0);
        req = '0;
        tick(); expect_empty("st_drain");

        // Requester 1 alone holds req through its ack: no second grant.
        set_req(1, 3'd1, 8'h81);
        tick(); expect_full("hold1", 3'd1, 8'h81, 2'd1, 4'b0010, 1'b0);
        tick(); expect_empty("hold1_masked");
        req = '0;
        tick(); expect_empty("hold1_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
